// File: rtl/formant_pkg.sv
// Shared types and constants for the formant angle-to-frequency path.
package formant_pkg;

  localparam int FORMANTS   = 5;
  localparam int PHI_WIDTH  = 24;
  localparam int FREQ_WIDTH = 16;
  localparam int HALF_FS    = 8000;
  localparam int MAX_FREQ   = 5000;

  localparam int IDX_W  = $clog2(FORMANTS);
  localparam int PROD_W = PHI_WIDTH + 15;
  localparam int RAW_W  = PROD_W - PHI_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND
  } state_t;

  typedef logic [0:FORMANTS-1][PHI_WIDTH-1:0] phi_arr_t;
  typedef logic [FREQ_WIDTH-1:0]              freq_t;
  typedef logic [RAW_W-1:0]                   raw_t;
  typedef logic [IDX_W-1:0]                   idx_t;

endpackage

// File: rtl/freq_smoother.sv
// Clamp and exponential smoothing of one formant per cycle; owns the per-formant
// smoothing state and exposes it through a read port for the output stream.
module freq_smoother
  import formant_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  vld_p1,
  input  idx_t  idx_p1,
  input  raw_t  f_raw_p1,
  input  logic  first_frame,
  input  idx_t  rd_idx,
  output freq_t rd_data
);

  freq_t s_mem [FORMANTS];
  freq_t f_c_p1;

  function automatic freq_t clamp_freq(input raw_t raw);
    if (raw > raw_t'(MAX_FREQ)) return freq_t'(MAX_FREQ);
    else                        return freq_t'(raw);
  endfunction

  // The signed step floors toward minus infinity on falling frequencies.
  function automatic freq_t iir_step(input freq_t s, input freq_t f_c);
    logic signed [FREQ_WIDTH:0] diff;
    logic signed [FREQ_WIDTH:0] step;
    diff = $signed({1'b0, f_c}) - $signed({1'b0, s});
    step = diff >>> ALPHA_SHIFT;
    return s + freq_t'(step[FREQ_WIDTH-1:0]);
  endfunction

  assign f_c_p1 = clamp_freq(f_raw_p1);

  // ---- stage 2: clamp + smoothing write ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < FORMANTS; k++) s_mem[k] <= '0;
    end else if (vld_p1) begin
      s_mem[idx_p1] <= first_frame ? f_c_p1 : iir_step(s_mem[idx_p1], f_c_p1);
    end
  end

  assign rd_data = s_mem[rd_idx];

endmodule

// File: rtl/phi_to_freq.sv
// Captures a frame of formant angles, converts each to Hz through a two-stage
// pipeline, and streams the smoothed frequencies over a valid/ready interface.
module phi_to_freq
  import formant_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  phi_arr_t phi_in,
  input  logic     phi_valid_in,
  output freq_t    freq_out,
  output idx_t     freq_idx_out,
  output logic     freq_last_out,
  output logic     freq_valid_out,
  input  logic     freq_ready_in,
  output logic     busy_out,
  output logic     overrun_out
);

  localparam idx_t           LAST_IDX = idx_t'(FORMANTS - 1);
  localparam logic [IDX_W:0] N_ISSUE  = (IDX_W + 1)'(FORMANTS);

  state_t           state;
  state_t           state_nxt;
  phi_arr_t         phi_reg;
  logic [IDX_W:0]   issue_idx;
  logic             issue_p0;
  logic [PROD_W-1:0] prod_p0;
  raw_t             f_raw_p1;
  idx_t             idx_p1;
  logic             vld_p1;
  logic             first_frame;
  idx_t             out_idx;
  logic             overrun_q;
  freq_t            s_rd;

  assign issue_p0 = (state == CALC) && (issue_idx < N_ISSUE);
  assign prod_p0  = PROD_W'(phi_reg[issue_idx[IDX_W-1:0]]) * PROD_W'(HALF_FS);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (phi_valid_in) state_nxt = CALC;
      CALC: if (vld_p1 && idx_p1 == LAST_IDX) state_nxt = SEND;
      SEND: if (freq_ready_in && out_idx == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      issue_idx   <= '0;
      vld_p1      <= 1'b0;
      idx_p1      <= '0;
      first_frame <= 1'b1;
      out_idx     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      overrun_q <= phi_valid_in && (state != IDLE);
      vld_p1    <= issue_p0;
      if (issue_p0) begin
        idx_p1    <= issue_idx[IDX_W-1:0];
        issue_idx <= issue_idx + (IDX_W + 1)'(1);
      end
      if (state == IDLE && phi_valid_in) issue_idx <= '0;
      if (state == CALC && state_nxt == SEND) begin
        first_frame <= 1'b0;
        out_idx     <= '0;
      end
      if (state == SEND && freq_ready_in)
        out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + idx_t'(1);
    end
  end

  // ---- stage 0 capture / stage 1 scale: f_raw = phi * HALF_FS >> PHI_WIDTH ----
  always_ff @(posedge clk_in) begin
    if (state == IDLE && phi_valid_in) phi_reg <= phi_in;
    if (issue_p0) f_raw_p1 <= prod_p0[PHI_WIDTH +: RAW_W];
  end

  freq_smoother #(
    .ALPHA_SHIFT (ALPHA_SHIFT)
  ) u_smoother (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .vld_p1      (vld_p1),
    .idx_p1      (idx_p1),
    .f_raw_p1    (f_raw_p1),
    .first_frame (first_frame),
    .rd_idx      (out_idx),
    .rd_data     (s_rd)
  );

  // ---- output stream ----
  always_comb begin
    freq_valid_out = 1'b0;
    freq_out       = '0;
    freq_idx_out   = '0;
    freq_last_out  = 1'b0;
    if (state == SEND) begin
      freq_valid_out = 1'b1;
      freq_out       = s_rd;
      freq_idx_out   = out_idx;
      freq_last_out  = (out_idx == LAST_IDX);
    end
  end

  assign busy_out    = (state != IDLE);
  assign overrun_out = overrun_q;

endmodule
